// File: rtl/prio_enc_stream_if.sv
// Handshake bundle for prio_enc_stream: request-vector input stream and
// encoded-index output stream.
interface prio_enc_stream_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_last;
  logic [W:0]   cnt;

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_last, cnt
  );

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_last, cnt
  );
endinterface

// File: rtl/prio_enc_stream.sv
// Streaming priority encoder: accepts a request vector, then emits the index of
// every set bit, lowest first, one beat per consumer handshake.
module prio_enc_stream #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input logic             clk,
  input logic             rst,
  prio_enc_stream_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  localparam logic [N-1:0] One = N'(1);

  state_e       state_q;
  logic [N-1:0] pend_q;
  logic [W-1:0] out_q;
  logic         out_valid_q;
  logic         out_last_q;
  logic [W:0]   cnt_q;

  logic         accept;
  logic         take;
  logic [N-1:0] pend_rest;

  function automatic logic [W-1:0] lsb_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [W:0] popcnt(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + (W + 1)'(v[i]);
    end
    return c;
  endfunction

  function automatic logic single_bit(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - One)) == '0);
  endfunction

  assign bus.in_ready = (state_q == StIdle) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign take         = out_valid_q && bus.out_ready;
  // Pending vector with its lowest set bit cleared.
  assign pend_rest    = pend_q & (pend_q - One);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            pend_q <= bus.in;
            cnt_q  <= popcnt(bus.in);
            // A zero vector is consumed silently and leaves the block idle.
            if (bus.in != '0) begin
              state_q     <= StScan;
              out_valid_q <= 1'b1;
              out_q       <= lsb_idx(bus.in);
              out_last_q  <= single_bit(bus.in);
            end
          end
        end
        StScan: begin
          if (take) begin
            pend_q <= pend_rest;
            if (out_last_q) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              out_q      <= lsb_idx(pend_rest);
              out_last_q <= single_bit(pend_rest);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_last  = out_last_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_prio_enc_stream.sv
// Scoreboard bench for prio_enc_stream: directed scenarios followed by random
// traffic, checked against a set-bit-list reference model.
module tb_prio_enc_stream;
  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef struct packed {
    logic [W-1:0] idx;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_enc_stream_if #(.N(N), .W(W)) bus ();

  prio_enc_stream #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t        expq[$];
  logic [W:0]   exp_cnt = '0;
  logic [W-1:0] last_out = '0;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           acc_cyc[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected beats: one per set bit, ascending index, last flag on the final one.
  task automatic expect_vec(input logic [N-1:0] v);
    int    k;
    beat_t b;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        b.idx  = W'(i);
        b.last = 1'b0;
        expq.push_back(b);
        k++;
      end
    end
    if (k > 0) begin
      b = expq.pop_back();
      b.last = 1'b1;
      expq.push_back(b);
    end
    exp_cnt = (W + 1)'(k);
  endtask

  task automatic cycle(input logic v, input logic [N-1:0] d, input logic r);
    logic acc;
    bus.in_valid  = v;
    bus.in        = d;
    bus.out_ready = r;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    cyc++;
    if (acc) begin
      expect_vec(d);
      acc_cyc.push_back(cyc);
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    expq.delete();
    exp_cnt = '0;
    repeat (n) cycle(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst) begin
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_out", int'(bus.out), 0);
        check("rst_cnt", int'(bus.cnt), 0);
        last_out = '0;
      end else begin
        check("in_ready", int'(bus.in_ready), int'(expq.size() == 0));
        check("out_valid", int'(bus.out_valid), int'(expq.size() != 0));
        check("cnt", int'(bus.cnt), int'(exp_cnt));
        if (expq.size() != 0) begin
          check("out", int'(bus.out), int'(expq[0].idx));
          check("out_last", int'(bus.out_last), int'(expq[0].last));
          if (bus.out_valid && bus.out_ready) begin
            last_out = expq[0].idx;
            void'(expq.pop_front());
          end
        end else begin
          check("idle_out_hold", int'(bus.out), int'(last_out));
          check("idle_out_last", int'(bus.out_last), 0);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] d;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // 1010_0100: beats 2, 5, 7 then ready again
    cycle(1'b1, 8'hA4, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);

    // 0xFF back to back: next acceptance 9 cycles after the first
    acc_cyc.delete();
    repeat (11) cycle(1'b1, 8'hFF, 1'b1);
    if (acc_cyc.size() >= 2) check("ff_accept_gap", acc_cyc[1] - acc_cyc[0], 9);
    else check("ff_accept_count", acc_cyc.size(), 2);
    repeat (10) cycle(1'b0, '0, 1'b1);

    // zero vector: no beats, cnt cleared, stays ready
    cycle(1'b1, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b1);

    // 0x12 with consumer stalled 3 cycles
    cycle(1'b1, 8'h12, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // 0x81 with 0x0F offered during the scan
    cycle(1'b1, 8'h81, 1'b1);
    repeat (2) cycle(1'b1, 8'h0F, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b1);

    // 0xF0 aborted by reset after beat 4, then acceptance on first edge after release
    cycle(1'b1, 8'hF0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    do_reset(2);
    cycle(1'b1, 8'h06, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       d = '0;
        1:       d = N'(1) << $urandom_range(0, N - 1);
        2:       d = N'($urandom) & N'($urandom);
        default: d = N'($urandom);
      endcase
      if (i == 200) do_reset(1);
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
    end

    repeat (N + 2) cycle(1'b0, '0, 1'b1);
    check("drain_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prio_enc_stream.md
PRIO_ENC_STREAM -- requirements
Module: prio_enc_stream

Interface
REQ-001 Parameter N, default 8: width of the request vector, legal range 2..32.
REQ-002 Parameter W, default $clog2(N): width of the encoded index output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request vector on `in` is offered.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 in  input  N  request vector; each set bit is one pending request.
REQ-008 out_valid  output  1  `out` holds a valid encoded index.
REQ-009 out_ready  input  1  consumer takes the current index.
REQ-010 out  output  W  binary index of the current request bit.
REQ-011 out_last  output  1  current beat is the final index of this vector.
REQ-012 cnt  output  W+1  number of set bits in the last accepted vector.

Function
REQ-013 Two states: IDLE and SCAN; the block SHALL leave reset in IDLE.
REQ-014 in_ready SHALL be 1 exactly when the state is IDLE and rst is low.
REQ-015 Accept on in_valid && in_ready: capture `in` into a pending register and load cnt with its popcount.
REQ-016 Accepting a nonzero vector SHALL move to SCAN; a zero vector SHALL stay in IDLE, emit no beat, and set cnt=0.
REQ-017 In SCAN out_valid SHALL be 1; out = index of the lowest-numbered set bit of the pending register.
REQ-018 out_last SHALL be 1 in SCAN exactly when the pending register has one set bit.
REQ-019 First out_valid SHALL assert the cycle after acceptance (latency 1).
REQ-020 On out_valid && out_ready, that bit SHALL be cleared; the next index SHALL be presented the following cycle.
REQ-021 A handshake with out_last=1 SHALL return to IDLE; in_ready SHALL be 1 the following cycle.
REQ-022 While out_valid && !out_ready, out, out_last and the pending register SHALL hold stable.
REQ-023 in_valid during SCAN SHALL be ignored; `in` has no effect on the pending register.
REQ-024 Throughput: a vector with k set bits (k>0) SHALL occupy k+1 cycles from acceptance to next acceptance under out_ready=1.
REQ-025 cnt SHALL hold its value until the next acceptance.
REQ-026 In IDLE, out_valid=0, out_last=0, and out SHALL hold its last value.

Reset
REQ-027 While rst is high: state=IDLE, pending=0, out_valid=0, out_last=0, out=0, cnt=0, in_ready=0.
REQ-028 rst asserted mid-SCAN SHALL abort immediately (asynchronously) and discard remaining requests.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-030 N=8, in=8'b1010_0100, out_ready=1 -> cnt=3; out = 2, 5, 7 on consecutive cycles; out_last only with 7; in_ready=1 the next cycle.
REQ-031 N=8, in=8'hFF, out_ready=1 -> out = 0..7 on 8 consecutive cycles; cnt=8; next acceptance 9 cycles after the first.
REQ-032 N=8, in=8'h00 accepted -> no out_valid; cnt=0; in_ready stays 1.
REQ-033 N=8, in=8'h12, out_ready low 3 cycles -> out=1 with out_valid=1 held 3 cycles, then 4 with out_last=1.
REQ-034 N=8, in=8'h81 accepted, in_valid=1 with in=8'h0F during SCAN -> beats 0, then 7 only; 8'h0F not captured.
REQ-035 N=8, in=8'hF0 accepted, rst pulsed after first beat (4) -> out_valid=0 and in_ready=0 during rst; state IDLE after release; no beats 5..7.
